// File: rtl/ro_response_reader_pkg.sv
// rtl/ro_response_reader_pkg.sv - shared types and constants for the RO PUF response reader.
package ro_reader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      COUNT,
      DRAIN,
      DONE
   } state_t;

   localparam int DRAIN_CYC   = 3;
   localparam int SYNC_STAGES = 2;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ro_response_reader_if.sv
// rtl/ro_response_reader_if.sv - host/RO-array bundle for the reader; RO_RAW_COUNT_EN adds CNT_A/CNT_B.
interface ro_response_reader_if #(
   parameter int CHAL_W = 8
`ifdef RO_RAW_COUNT_EN
   , parameter int CNT_W = 16
`endif
);
   logic              START;
   logic [CHAL_W-1:0] CHAL;
   logic              RO_A;
   logic              RO_B;
   logic [CHAL_W-1:0] CHAL_OUT;
   logic              RO_EN;
   logic              BUSY;
   logic              RESP;
   logic              TIE;
   logic              RESP_VALID;
`ifdef RO_RAW_COUNT_EN
   logic [CNT_W-1:0]  CNT_A;
   logic [CNT_W-1:0]  CNT_B;

   modport master (output START, CHAL, RO_A, RO_B,
                   input  CHAL_OUT, RO_EN, BUSY, RESP, TIE, RESP_VALID, CNT_A, CNT_B);
   modport slave  (input  START, CHAL, RO_A, RO_B,
                   output CHAL_OUT, RO_EN, BUSY, RESP, TIE, RESP_VALID, CNT_A, CNT_B);
`else
   modport master (output START, CHAL, RO_A, RO_B,
                   input  CHAL_OUT, RO_EN, BUSY, RESP, TIE, RESP_VALID);
   modport slave  (input  START, CHAL, RO_A, RO_B,
                   output CHAL_OUT, RO_EN, BUSY, RESP, TIE, RESP_VALID);
`endif
endinterface

// File: rtl/ro_response_reader_edge_counter.sv
// rtl/ro_response_reader_edge_counter.sv - synchronizes one RO output and counts its rising edges, saturating.
module ro_edge_counter
   import ro_reader_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             EN,
   input  logic             RO_IN,
   output logic [CNT_W-1:0] CNT
);

   // Bits [SYNC_STAGES-1:0] are the synchronizer; the top bit is the delayed copy for edge detection.
   logic [SYNC_STAGES:0] sync_q, sync_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 edge_det;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-1:0], RO_IN};
      edge_det = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
      cnt_d    = cnt_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (EN && edge_det && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end

   assign CNT = cnt_q;

endmodule

// File: rtl/ro_response_reader.sv
// rtl/ro_response_reader.sv - drives a challenge into two RO chains, counts both over a window, emits one response bit.
// Define RO_RAW_COUNT_EN to also expose the final counts as CNT_A/CNT_B.
module ro_response_reader
   import ro_reader_pkg::*;
#(
   parameter int CHAL_W     = 8,
   parameter int CNT_W      = 16,
   parameter int WINDOW     = 1024,
   parameter int SETTLE_CYC = 4
) (
   input logic                  CLK,
   input logic                  RST,
   ro_response_reader_if.slave  bus
);

   localparam int TMR_MAX = max_i(max_i(WINDOW, SETTLE_CYC), DRAIN_CYC);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CHAL_W-1:0]  chal_q, chal_d;
   logic               resp_q, resp_d;
   logic               tie_q, tie_d;
   logic               rv_q, rv_d;
   logic               clr;
   logic               cnt_en;
   logic [CNT_W-1:0]   cnt_a, cnt_b;

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .CLK   (CLK),
      .RST   (RST),
      .CLR   (clr),
      .EN    (cnt_en),
      .RO_IN (bus.RO_A),
      .CNT   (cnt_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .CLK   (CLK),
      .RST   (RST),
      .CLR   (clr),
      .EN    (cnt_en),
      .RO_IN (bus.RO_B),
      .CNT   (cnt_b)
   );

   // Counting continues through DRAIN so edges still inside the synchronizers are not lost.
   assign cnt_en = (state_q == COUNT) || (state_q == DRAIN);

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      chal_d  = chal_q;
      resp_d  = resp_q;
      tie_d   = tie_q;
      rv_d    = 1'b0;
      clr     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.START) begin
               chal_d  = bus.CHAL;
               clr     = 1'b1;
               tmr_d   = TMR_W'(SETTLE_CYC - 1);
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (tmr_q == '0) begin
               tmr_d   = TMR_W'(WINDOW - 1);
               state_d = COUNT;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         COUNT: begin
            if (tmr_q == '0) begin
               tmr_d   = TMR_W'(DRAIN_CYC - 1);
               state_d = DRAIN;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         DRAIN: begin
            if (tmr_q == '0) begin
               state_d = DONE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         DONE: begin
            resp_d  = (cnt_a > cnt_b);
            tie_d   = (cnt_a == cnt_b);
            rv_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         chal_q  <= '0;
         resp_q  <= 1'b0;
         tie_q   <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         chal_q  <= chal_d;
         resp_q  <= resp_d;
         tie_q   <= tie_d;
         rv_q    <= rv_d;
      end
   end

`ifdef RO_RAW_COUNT_EN
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (state_q == DONE) begin
         cnt_a_d = cnt_a;
         cnt_b_d = cnt_b;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign bus.CNT_A = cnt_a_q;
   assign bus.CNT_B = cnt_b_q;
`endif

   assign bus.CHAL_OUT   = chal_q;
   assign bus.RO_EN      = (state_q == COUNT);
   assign bus.BUSY       = (state_q != IDLE);
   assign bus.RESP       = resp_q;
   assign bus.TIE        = tie_q;
   assign bus.RESP_VALID = rv_q;

endmodule

// File: doc/ro_response_reader.md
Name: ro_response_reader

Overview:
- Reader end of the PUF ring-oscillator path.
- Drives challenge bits and enable into the Double_SLICE-based RO chains, then counts the oscillation edges of two competing ROs over a fixed gate window.
- Compares the two counts and emits one response bit per challenge.
- Sits between the challenge source (host/UART/encryption wrapper) and the RO array.

Parameters:
- CHAL_W, 8, width of challenge word driven to the slice SEL/BX inputs.
- CNT_W, 16, width of each edge counter; counters saturate at 2^CNT_W-1.
- WINDOW, 1024, number of CLK cycles RO_EN is held high (count window); must be ≥1.
- SETTLE_CYC, 4, cycles the challenge is applied with RO_EN low before counting; must be ≥1.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request a measurement; sampled only in IDLE.
- CHAL  input  CHAL_W  challenge; latched on accepted START.
- RO_A  input  1  asynchronous oscillator output, chain A.
- RO_B  input  1  asynchronous oscillator output, chain B.
- CHAL_OUT  output  CHAL_W  latched challenge to the RO chains' SEL/BX inputs.
- RO_EN  output  1  enable to both RO chains.
- BUSY  output  1  high in every state except IDLE.
- RESP  output  1  response bit; 1 iff count_A > count_B.
- TIE  output  1  count_A == count_B.
- RESP_VALID  output  1  one-cycle pulse; RESP/TIE are valid in that cycle.

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-high.
- Reset values: all outputs are 0; state = IDLE; both counters = 0.
- FSM states: IDLE, SETTLE, COUNT, DRAIN, DONE.
- IDLE:
  - START=1 latches CHAL into CHAL_OUT, clears both counters, and moves to SETTLE.
  - START=0 holds the state. CHAL_OUT holds its last value.
- SETTLE: RO_EN=0 for exactly SETTLE_CYC cycles, then COUNT.
- COUNT:
  - RO_EN=1 for exactly WINDOW cycles, then DRAIN.
  - Counters are enabled.
- DRAIN:
  - RO_EN=0 for exactly 3 cycles, so edges still in the 2-FF synchronizers are flushed.
  - Counters remain enabled.
  - Then DONE.
- DONE:
  - RESP = (cnt_A > cnt_B) and TIE = (cnt_A == cnt_B), both registered.
  - RESP_VALID=1 for this single cycle, then IDLE.
- Output hold: RESP and TIE hold their values until the next DONE or RST.
- Latency: START sampled at edge k gives RESP_VALID high in the cycle after edge k+SETTLE_CYC+WINDOW+4.
- Edge counting:
  - Each RO input passes through a 2-FF synchronizer and a rising-edge detector (sync2 & ~sync3).
  - A detected edge increments the counter by 1, only while counting is enabled.
- Saturation: a counter at 2^CNT_W-1 stays there; it never wraps.
- Tie: RESP=0 and TIE=1.
- START while BUSY: ignored, with no effect on state or CHAL_OUT.
- START held high continuously: a new measurement begins in the cycle after returning to IDLE.
- RST mid-operation (any state): next cycle has state=IDLE, RO_EN=0, BUSY=0, RESP_VALID=0, counters=0, CHAL_OUT=0. No partial RESP_VALID is emitted.
- CHAL changing during BUSY: no effect.

Optional Feature:
- Macro: RO_RAW_COUNT_EN.
- With the macro defined:
  - Extra outputs CNT_A and CNT_B (CNT_W each) expose the final counts, registered in DONE alongside RESP and valid with RESP_VALID.
  - They hold until the next DONE and reset to 0.
- Without the macro: these ports do not exist; behaviour is otherwise identical.

Decomposition:
- Package ro_reader_pkg contains:
  - state enum typedef (IDLE, SETTLE, COUNT, DRAIN, DONE);
  - localparam DRAIN_CYC = 3;
  - SYNC_STAGES = 2.
- One sub-module: ro_edge_counter (parameter CNT_W; ports CLK, RST, CLR, EN, RO_IN, CNT).
  - Contains the synchronizer, the edge detector and the saturating counter.
  - Instantiated twice (A, B).

Test Plan:
- Basic compare. Setup: WINDOW=1200, SETTLE_CYC=4; RO_A toggles every 2 CLK, RO_B every 3 CLK; START with CHAL=8'hA5. Required:
  - CHAL_OUT=8'hA5 from the next cycle;
  - RO_EN high exactly 1200 cycles;
  - RESP_VALID at START+1209 with RESP=1, TIE=0;
  - with RO_RAW_COUNT_EN: CNT_A=300±1, CNT_B=200±1.
- Swap: same setup with the RO_A/RO_B rates swapped → RESP=0, TIE=0.
- Tie: both ROs toggle every 2 CLK from the same edge → RESP=0, TIE=1.
- Saturation: CNT_W=4, WINDOW=200, RO_A fast (period 2 CLK), RO_B period 40 CLK → count_A saturates at 15, count_B=5, RESP=1; no wrap.
- Busy and reset: START pulsed during COUNT with CHAL=8'h3C → ignored, CHAL_OUT unchanged. Then RST asserted mid-COUNT → next cycle RO_EN=0, BUSY=0, CHAL_OUT=0, and no RESP_VALID for 2000 cycles.
- Back-to-back: START held high for 3 measurements → 3 RESP_VALID pulses spaced SETTLE_CYC+WINDOW+5 cycles apart, each a single cycle wide.
